// File: rtl/slip_rx_fifo.sv
// SLIP receive decoder feeding a first-word-fall-through output FIFO.
// Decoded frames are written byte by byte with per-entry last/error flags.
// The final byte of each frame is held back until its terminating END.
module slip_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               din,
    input  logic                     din_rdy,
    output logic                     frame,
    output logic [7:0]               dout,
    output logic                     dout_last,
    output logic                     dout_err,
    output logic                     dout_rdy,
    input  logic                     dout_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    localparam logic [7:0]  C_END     = 8'hC0;
    localparam logic [7:0]  C_ESC     = 8'hDB;
    localparam logic [7:0]  C_ESC_END = 8'hDC;
    localparam logic [7:0]  C_ESC_ESC = 8'hDD;
    localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        READ,
        ESC,
        DROP
    } state_t;

    // FIFO entry layout: {err, last, data}
    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } entry_t;

    state_t            state;
    logic              pend_valid;
    logic [7:0]        pend_data;
    logic [15:0]       cnt;

    logic              dec_valid;
    logic [7:0]        dec_byte;
    logic              bad_esc;
    logic              overlen;
    logic              abort;
    logic              end_push;
    logic              push;
    entry_t            push_entry;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              push_lost;

    // Classify the incoming byte: decoded data byte or bad escape sequence.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        dec_valid = 1'b0;
        dec_byte  = din;
        bad_esc   = 1'b0;
        if (din_rdy) begin
            case (state)
                READ: begin
                    if (din != C_END && din != C_ESC) begin
                        dec_valid = 1'b1;
                    end
                end
                ESC: begin
                    if (din == C_ESC_END) begin
                        dec_valid = 1'b1;
                        dec_byte  = C_END;
                    end else if (din == C_ESC_ESC) begin
                        dec_valid = 1'b1;
                        dec_byte  = C_ESC;
                    end else begin
                        bad_esc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A decoded byte beyond MAX_LEN aborts the frame just like a bad escape.
    assign overlen  = dec_valid && (cnt == LEN_LIMIT);
    assign abort    = bad_esc || overlen;
    assign end_push = din_rdy && (state == READ) && (din == C_END) && pend_valid;

    // The held byte is released when a newer byte arrives, the frame ends, or it aborts.
    assign push            = abort || end_push || (dec_valid && !overlen && pend_valid);
    assign push_entry.err  = abort;
    assign push_entry.last = abort || end_push;
    assign push_entry.data = pend_valid ? pend_data : 8'h00;

    assign full      = (level == LEVEL_W'(DEPTH));
    assign pop       = dout_ack && dout_rdy;
    assign wr_en     = push && (!full || pop);
    assign push_lost = push && full && !pop;

    // Decoder state machine: frame tracking, held byte and per-frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            pend_valid <= 1'b0;
            pend_data  <= 8'h00;
            cnt        <= 16'd0;
            frame      <= 1'b0;
        end else if (push_lost || abort) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pend_valid <= 1'b0;
            frame      <= 1'b0;
            state      <= DROP;
        end else if (dec_valid) begin
            pend_data  <= dec_byte;
            pend_valid <= 1'b1;
            cnt        <= cnt + 16'd1;
            frame      <= 1'b1;
            state      <= READ;
        end else if (din_rdy) begin
            case (state)
                HUNT: begin
                    if (din == C_END) begin
                        state <= READ;
                        cnt   <= 16'd0;
                    end
                end
                READ: begin
                    if (din == C_END) begin
                        pend_valid <= 1'b0;
                        frame      <= 1'b0;
                        cnt        <= 16'd0;
                    end else if (din == C_ESC) begin
                        state <= ESC;
                        frame <= 1'b1;
                    end
                end
                DROP: begin
                    if (din == C_END) begin
                        state <= READ;
                        cnt   <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; emptiness is tracked by level and the outputs are masked.
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (push_lost) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign dout_rdy = (level != '0);
    assign head     = mem[rd_ptr];
    assign dout      = dout_rdy ? head.data : 8'h00;
    assign dout_last = dout_rdy ? head.last : 1'b0;
    assign dout_err  = dout_rdy ? head.err  : 1'b0;

endmodule
